// File: rtl/aes_job_sched.sv
// aes_job_sched: runs whole 128-bit jobs through one byte-serial aes_8_bit core
// and shares that core between two requesters with round-robin arbitration.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | core held in reset; grant a pending request and latch its vectors
//   CRST  | one extra cycle of core reset before streaming starts
//   LOAD  | 16 key/data byte pairs presented to the core, MSB byte first
//   WAIT  | waiting for core d_vld; abort with error after TIMEOUT cycles
//   CAPT  | remaining 15 result bytes shifted in, one per cycle
//   RESP  | result presented until the requester side accepts it
//
// Every output is a register. The next-state block computes the value each
// output takes in the following state, so the outputs line up with the state.
module aes_job_sched #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_vld,
    output logic [1:0]   req_rdy,
    input  logic [127:0] req0_key,
    input  logic [127:0] req0_data,
    input  logic [127:0] req1_key,
    input  logic [127:0] req1_data,
    output logic         rsp_vld,
    input  logic         rsp_rdy,
    output logic         rsp_id,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    output logic         core_rst,
    output logic [7:0]   core_key,
    output logic [7:0]   core_din,
    input  logic [7:0]   core_dout,
    input  logic         core_dvld,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CRST = 3'd1,
        S_LOAD = 3'd2,
        S_WAIT = 3'd3,
        S_CAPT = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t         r_state,    w_state_n;
    logic           r_rr,       w_rr_n;
    logic [127:0]   r_key_sr,   w_key_sr_n;
    logic [127:0]   r_data_sr,  w_data_sr_n;
    logic [127:0]   r_res_sr,   w_res_sr_n;
    logic [3:0]     r_bc,       w_bc_n;
    logic [CW-1:0]  r_wc,       w_wc_n;
    logic           r_core_rst, w_core_rst_n;
    logic [7:0]     r_core_key, w_core_key_n;
    logic [7:0]     r_core_din, w_core_din_n;
    logic [1:0]     r_req_rdy,  w_req_rdy_n;
    logic           r_rsp_vld,  w_rsp_vld_n;
    logic           r_rsp_id,   w_rsp_id_n;
    logic [127:0]   r_rsp_data, w_rsp_data_n;
    logic           r_rsp_err,  w_rsp_err_n;
    logic           r_busy,     w_busy_n;
    logic           w_gnt;

    // State and output registers; reset abandons any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr       <= 1'b0;
            r_key_sr   <= '0;
            r_data_sr  <= '0;
            r_res_sr   <= '0;
            r_bc       <= '0;
            r_wc       <= '0;
            r_core_rst <= 1'b1;
            r_core_key <= '0;
            r_core_din <= '0;
            r_req_rdy  <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_id   <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_rr       <= w_rr_n;
            r_key_sr   <= w_key_sr_n;
            r_data_sr  <= w_data_sr_n;
            r_res_sr   <= w_res_sr_n;
            r_bc       <= w_bc_n;
            r_wc       <= w_wc_n;
            r_core_rst <= w_core_rst_n;
            r_core_key <= w_core_key_n;
            r_core_din <= w_core_din_n;
            r_req_rdy  <= w_req_rdy_n;
            r_rsp_vld  <= w_rsp_vld_n;
            r_rsp_id   <= w_rsp_id_n;
            r_rsp_data <= w_rsp_data_n;
            r_rsp_err  <= w_rsp_err_n;
            r_busy     <= w_busy_n;
        end
    end

    // Next state plus the output values that belong to that next state.
    always_comb begin
        w_state_n    = r_state;
        w_rr_n       = r_rr;
        w_key_sr_n   = r_key_sr;
        w_data_sr_n  = r_data_sr;
        w_res_sr_n   = r_res_sr;
        w_bc_n       = r_bc;
        w_wc_n       = r_wc;
        w_core_rst_n = r_core_rst;
        w_core_key_n = r_core_key;
        w_core_din_n = r_core_din;
        w_req_rdy_n  = 2'b00;
        w_rsp_vld_n  = r_rsp_vld;
        w_rsp_id_n   = r_rsp_id;
        w_rsp_data_n = r_rsp_data;
        w_rsp_err_n  = r_rsp_err;
        w_gnt        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_core_rst_n = 1'b1;
                if (|req_vld) begin
                    // Contention resolves to the pointer; a lone request wins outright.
                    w_gnt       = (&req_vld) ? r_rr : req_vld[1];
                    w_req_rdy_n = {w_gnt, ~w_gnt};
                    w_key_sr_n  = w_gnt ? req1_key  : req0_key;
                    w_data_sr_n = w_gnt ? req1_data : req0_data;
                    w_rsp_id_n  = w_gnt;
                    w_rr_n      = ~w_gnt;
                    w_state_n   = S_CRST;
                end
            end

            S_CRST: begin
                w_core_rst_n = 1'b0;
                w_core_key_n = r_key_sr[127:120];
                w_core_din_n = r_data_sr[127:120];
                w_key_sr_n   = {r_key_sr[119:0], 8'h00};
                w_data_sr_n  = {r_data_sr[119:0], 8'h00};
                w_bc_n       = 4'd0;
                w_state_n    = S_LOAD;
            end

            S_LOAD: begin
                if (r_bc == 4'd15) begin
                    w_core_key_n = 8'h00;
                    w_core_din_n = 8'h00;
                    // wc counts WAIT cycles including the current one.
                    w_wc_n       = CW'(1);
                    w_state_n    = S_WAIT;
                end else begin
                    w_core_key_n = r_key_sr[127:120];
                    w_core_din_n = r_data_sr[127:120];
                    w_key_sr_n   = {r_key_sr[119:0], 8'h00};
                    w_data_sr_n  = {r_data_sr[119:0], 8'h00};
                    w_bc_n       = r_bc + 4'd1;
                end
            end

            S_WAIT: begin
                // d_vld is tested first so data arriving on the last allowed cycle wins.
                if (core_dvld) begin
                    w_res_sr_n = {r_res_sr[119:0], core_dout};
                    w_bc_n     = 4'd1;
                    w_state_n  = S_CAPT;
                end else if (r_wc == CW'(TIMEOUT)) begin
                    w_rsp_vld_n  = 1'b1;
                    w_rsp_err_n  = 1'b1;
                    w_rsp_data_n = '0;
                    w_state_n    = S_RESP;
                end else begin
                    w_wc_n = r_wc + CW'(1);
                end
            end

            S_CAPT: begin
                w_res_sr_n = {r_res_sr[119:0], core_dout};
                if (r_bc == 4'd15) begin
                    w_rsp_vld_n  = 1'b1;
                    w_rsp_err_n  = 1'b0;
                    w_rsp_data_n = {r_res_sr[119:0], core_dout};
                    w_state_n    = S_RESP;
                end else begin
                    w_bc_n = r_bc + 4'd1;
                end
            end

            S_RESP: begin
                if (rsp_rdy) begin
                    w_rsp_vld_n  = 1'b0;
                    w_core_rst_n = 1'b1;
                    w_state_n    = S_IDLE;
                end
            end

            default: begin
                w_core_rst_n = 1'b1;
                w_state_n    = S_IDLE;
            end
        endcase

        w_busy_n = (w_state_n != S_IDLE);
    end

    assign req_rdy  = r_req_rdy;
    assign rsp_vld  = r_rsp_vld;
    assign rsp_id   = r_rsp_id;
    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;
    assign core_rst = r_core_rst;
    assign core_key = r_core_key;
    assign core_din = r_core_din;
    assign busy     = r_busy;

endmodule

// File: tb/tb_aes_job_sched.sv
// Bench for aes_job_sched: behavioural byte-serial AES core plus directed jobs.
module tb_aes_job_sched;

    localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] PC = 128'hdeadbeef0123456789abcdeffedcba98;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_vld;
    logic [1:0]   req_rdy;
    logic [127:0] req0_key, req0_data, req1_key, req1_data;
    logic         rsp_vld, rsp_rdy, rsp_id, rsp_err;
    logic [127:0] rsp_data;
    logic         core_rst;
    logic [7:0]   core_key, core_din;
    logic [7:0]   core_dout;
    logic         core_dvld;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aes_job_sched #(.TIMEOUT(20), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req0_key(req0_key), .req0_data(req0_data),
        .req1_key(req1_key), .req1_data(req1_data),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_rst(core_rst), .core_key(core_key), .core_din(core_din),
        .core_dout(core_dout), .core_dvld(core_dvld), .busy(busy)
    );

    // ---------------- AES-128 reference ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            inv = 8'h00;
            if (v != 0)
                for (int u = 1; u < 256; u++)
                    if (gm(x, 8'(u)) == 8'h01) inv = 8'(u);
            sb[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   b [16];
        logic [7:0]   n [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] s;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) b[i] = sb[s[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int ro = 0; ro < 4; ro++)
                    n[4*c+ro] = b[4*((c+ro)%4)+ro];
            for (int c = 0; c < 4; c++) begin
                a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
                if (r < 10) begin
                    b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    b[4*c] = a0; b[4*c+1] = a1; b[4*c+2] = a2; b[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = b[i];
            s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    // ---------------- behavioural aes_8_bit core ----------------
    // Samples 16 byte pairs after reset, raises d_vld core_dly+1 cycles into
    // WAIT, then streams the 16 result bytes MSB first and holds d_vld.
    bit           core_en  = 1'b1;
    int           core_dly = 3;
    int           pc, oc;
    logic [127:0] m_key, m_pt, m_ct;
    logic [7:0]   m_dout;
    logic         m_dvld;

    assign core_dout = m_dout;
    assign core_dvld = m_dvld;

    always @(posedge clk) begin
        if (core_rst) begin
            pc     <= 0;
            oc     <= 0;
            m_dvld <= 1'b0;
            m_dout <= 8'h00;
        end else begin
            if (pc < 16) begin
                m_key <= {m_key[119:0], core_key};
                m_pt  <= {m_pt[119:0], core_din};
            end
            if (pc == 15) m_ct <= aes128({m_key[119:0], core_key}, {m_pt[119:0], core_din});
            if (pc < 100000) pc <= pc + 1;
            if (core_en && pc == 15 + core_dly) begin
                m_dvld <= 1'b1;
                m_dout <= m_ct[127:120];
                oc     <= 1;
            end else if (m_dvld && oc < 16) begin
                m_dout <= m_ct[127-8*oc -: 8];
                oc     <= oc + 1;
            end
        end
    end

    // Log of every req_rdy pulse seen.
    logic [1:0] gq [$];
    always @(negedge clk) if (req_rdy != 2'b00) gq.push_back(req_rdy);

    // ---------------- helpers (no checking) ----------------
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic grant_wait(input logic [1:0] which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (req_rdy == which) ok = 1'b1;
        end
    endtask

    task automatic wait_rsp(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (rsp_vld) ok = 1'b1;
            else if (!core_rst) cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; req_vld = 2'b00; rsp_rdy = 1'b1;
        req0_key = '0; req0_data = '0; req1_key = '0; req1_data = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({core_rst, core_key, core_din} !== {1'b1, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_core: got rst=%b key=%h din=%h, expected 1 00 00", core_rst, core_key, core_din);
        end
        n_checks++;
        if ({req_rdy, rsp_vld, rsp_id, rsp_err, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b id=%b err=%b busy=%b, expected all 0",
                     req_rdy, rsp_vld, rsp_id, rsp_err, busy);
        end
        n_checks++;
        if (rsp_data !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, expected 0", rsp_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_fips();
        bit ok; int cyc; logic [127:0] ks, ds;
        gq.delete();
        req0_key = KA; req0_data = PA; rsp_rdy = 1'b1; req_vld = 2'b01;
        grant_wait(2'b01, ok);
        req_vld = 2'b00;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL fips_grant: no req_rdy=01 within 10 cycles, expected grant"); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL fips_busy: got %b, expected 1", busy); end
        @(negedge clk);
        n_checks++;
        if (core_rst !== 1'b0) begin n_fail++; $display("FAIL fips_crst: core_rst got %b, expected 0 two cycles after grant", core_rst); end
        ks = '0; ds = '0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            ks = {ks[119:0], core_key};
            ds = {ds[119:0], core_din};
        end
        n_checks++;
        if (ks !== KA) begin n_fail++; $display("FAIL fips_key_stream: got %h, expected %h", ks, KA); end
        n_checks++;
        if (ds !== PA) begin n_fail++; $display("FAIL fips_data_stream: got %h, expected %h", ds, PA); end
        wait_rsp(cyc, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL fips_rsp_timeout: rsp_vld absent after 400 cycles, expected 1"); end
        n_checks++;
        if (rsp_data !== CA) begin n_fail++; $display("FAIL fips_data: got %h, expected %h", rsp_data, CA); end
        n_checks++;
        if ({rsp_id, rsp_err} !== 2'b00) begin n_fail++; $display("FAIL fips_id_err: got id=%b err=%b, expected 0 0", rsp_id, rsp_err); end
        n_checks++;
        if (cyc + 15 !== 34) begin n_fail++; $display("FAIL fips_latency: got %0d core-active cycles, expected 35", cyc + 16); end
        @(negedge clk);
        n_checks++;
        if ({rsp_vld, core_rst, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL fips_handshake: got vld=%b core_rst=%b busy=%b, expected 0 1 0", rsp_vld, core_rst, busy);
        end
        n_checks++;
        if (gq.size() !== 1 || gq[0] !== 2'b01) begin
            n_fail++;
            $display("FAIL fips_grants: got %0d pulses, expected one pulse of 01", gq.size());
        end
    endtask

    task automatic test_round_robin();
        bit ok; int cyc; logic [127:0] exp_d;
        pulse_reset();
        gq.delete();
        req0_key = KA; req0_data = PA; req1_key = KB; req1_data = PB;
        rsp_rdy = 1'b1; req_vld = 2'b11;
        for (int j = 0; j < 4; j++) begin
            wait_rsp(cyc, ok);
            if (j == 3) req_vld = 2'b00;
            exp_d = (j % 2 == 1) ? aes128(KB, PB) : aes128(KA, PA);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL rr_rsp_timeout: job %0d no rsp_vld, expected 1", j); end
            n_checks++;
            if (rsp_id !== 1'(j % 2)) begin n_fail++; $display("FAIL rr_id: job %0d got %b, expected %0d", j, rsp_id, j % 2); end
            n_checks++;
            if (rsp_data !== exp_d) begin n_fail++; $display("FAIL rr_data: job %0d got %h, expected %h", j, rsp_data, exp_d); end
            if (j == 1) begin
                n_checks++;
                if (rsp_data !== CB) begin n_fail++; $display("FAIL rr_fips_b: got %h, expected %h", rsp_data, CB); end
            end
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (gq.size() !== 4) begin n_fail++; $display("FAIL rr_grant_count: got %0d, expected 4", gq.size()); end
        for (int j = 0; j < 4 && j < gq.size(); j++) begin
            n_checks++;
            if (gq[j] !== ((j % 2 == 1) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_grant_order: grant %0d got %b, expected %b", j, gq[j], (j % 2 == 1) ? 2'b10 : 2'b01);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok; int cyc; int bad; logic [127:0] exp_d;
        exp_d = aes128(KC, PC);
        req0_key = KC; req0_data = PC; req1_key = KB; req1_data = PB;
        rsp_rdy = 1'b0; req_vld = 2'b01;
        grant_wait(2'b01, ok);
        req_vld = 2'b10;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_grant: no req_rdy=01, expected grant"); end
        wait_rsp(cyc, ok);
        n_checks++;
        if (!ok || rsp_data !== exp_d || rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_first: got vld=%b id=%b data=%h, expected 1 0 %h", ok, rsp_id, rsp_data, exp_d);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_vld !== 1'b1 || rsp_data !== exp_d || rsp_id !== 1'b0 || req_rdy !== 2'b00 || core_rst !== 1'b0) begin
                n_fail++;
                if (bad < 3)
                    $display("FAIL bp_hold: cycle %0d got vld=%b id=%b rdy=%b core_rst=%b data=%h, expected 1 0 00 0 %h",
                             i, rsp_vld, rsp_id, req_rdy, core_rst, rsp_data, exp_d);
                bad++;
            end
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rsp_vld, core_rst, req_rdy} !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_handshake: got vld=%b core_rst=%b rdy=%b, expected 0 1 00", rsp_vld, core_rst, req_rdy);
        end
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 2'b10) begin n_fail++; $display("FAIL bp_next_grant: got %b, expected 10", req_rdy); end
        req_vld = 2'b00;
        wait_rsp(cyc, ok);
        n_checks++;
        if (!ok || rsp_data !== CB || rsp_id !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: got vld=%b id=%b data=%h, expected 1 1 %h", ok, rsp_id, rsp_data, CB);
        end
    endtask

    task automatic test_timeout();
        bit ok; int cyc;
        core_en = 1'b0;
        req0_key = KB; req0_data = PB; rsp_rdy = 1'b1; req_vld = 2'b01;
        grant_wait(2'b01, ok);
        req_vld = 2'b00;
        wait_rsp(cyc, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL to_rsp_timeout: no rsp_vld, expected 1"); end
        n_checks++;
        if ({rsp_err, rsp_id} !== 2'b10) begin n_fail++; $display("FAIL to_err: got err=%b id=%b, expected 1 0", rsp_err, rsp_id); end
        n_checks++;
        if (rsp_data !== 128'h0) begin n_fail++; $display("FAIL to_data: got %h, expected 0", rsp_data); end
        n_checks++;
        if (cyc !== 36) begin n_fail++; $display("FAIL to_wait_cycles: got %0d WAIT cycles, expected 20", cyc - 16); end
        core_en = 1'b1;
        req0_key = KA; req0_data = PA; req_vld = 2'b01;
        grant_wait(2'b01, ok);
        req_vld = 2'b00;
        wait_rsp(cyc, ok);
        n_checks++;
        if (!ok || rsp_data !== CA || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_recover: got vld=%b err=%b data=%h, expected 1 0 %h", ok, rsp_err, rsp_data, CA);
        end
    endtask

    task automatic test_dvld_at_timeout();
        bit ok; int cyc; logic [127:0] exp_d;
        exp_d = aes128(KC, PC);
        core_dly = 19;
        req1_key = KC; req1_data = PC; rsp_rdy = 1'b1; req_vld = 2'b10;
        grant_wait(2'b10, ok);
        req_vld = 2'b00;
        wait_rsp(cyc, ok);
        n_checks++;
        if (!ok || rsp_err !== 1'b0) begin n_fail++; $display("FAIL edge_err: got vld=%b err=%b, expected 1 0", ok, rsp_err); end
        n_checks++;
        if (rsp_data !== exp_d || rsp_id !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_data: got id=%b data=%h, expected 1 %h", rsp_id, rsp_data, exp_d);
        end
        n_checks++;
        if (cyc !== 51) begin n_fail++; $display("FAIL edge_latency: got %0d core-active cycles, expected 51", cyc); end
        core_dly = 3;
    endtask

    task automatic test_mid_reset();
        bit ok; int cyc; int seen;
        req0_key = KB; req0_data = PB; rsp_rdy = 1'b1; req_vld = 2'b01;
        grant_wait(2'b01, ok);
        req_vld = 2'b00;
        @(negedge clk);
        repeat (7) @(negedge clk);
        n_checks++;
        if ({core_rst, core_key, core_din} !== {1'b0, KB[71:64], PB[71:64]}) begin
            n_fail++;
            $display("FAIL mr_byte7: got rst=%b key=%h din=%h, expected 0 %h %h", core_rst, core_key, core_din, KB[71:64], PB[71:64]);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({core_rst, core_key, core_din, busy} !== {1'b1, 8'h00, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL mr_async_core: got rst=%b key=%h din=%h busy=%b, expected 1 00 00 0", core_rst, core_key, core_din, busy);
        end
        n_checks++;
        if ({req_rdy, rsp_vld, rsp_id, rsp_err} !== 5'b0 || rsp_data !== 128'h0) begin
            n_fail++;
            $display("FAIL mr_async_rsp: got rdy=%b vld=%b id=%b err=%b data=%h, expected zeros", req_rdy, rsp_vld, rsp_id, rsp_err, rsp_data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_vld || busy) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL mr_no_rsp: got %0d active cycles after reset, expected 0", seen); end
        req_vld = 2'b01;
        grant_wait(2'b01, ok);
        req_vld = 2'b00;
        wait_rsp(cyc, ok);
        n_checks++;
        if (!ok || rsp_data !== CB || {rsp_id, rsp_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL mr_resubmit: got vld=%b id=%b err=%b data=%h, expected 1 0 0 %h", ok, rsp_id, rsp_err, rsp_data, CB);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_vld = 2'b00;
        rsp_rdy = 1'b1;
        build_sbox();
        test_reset();
        test_fips();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_dvld_at_timeout();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
